// File: rtl/multi_pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator: default
// parameter values, the sequencer state encoding and a clamp helper.
package multi_pulse_gen_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_MIN_T   = 1000;
  localparam int DEF_MAX_T   = 30303;
  localparam int DEF_MIN_TPH = 10;
  localparam int DEF_MAX_TPH = 990;
  localparam int DEF_PERIOD  = 2000;
  localparam int DEF_HIGH    = 250;
  localparam int DEF_BURST_W = 8;

  // Burst length value meaning "run until stopped".
  localparam int BURST_CONTINUOUS = 0;

  // ST_LAST: the period in progress is the final one (burst exhausted or
  // stop requested); the sequencer drops to idle at its wrap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  function automatic int unsigned clamp_u(input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/multi_pulse_gen_channel.sv
// One pulse channel: double-buffered high time and phase delay, window
// comparator against the shared period counter, registered output.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   load_i            capture cfg_tph_i/cfg_delay_i into the pending set
//   apply_i           copy pending set to active set
//   busy_i, cnt_i     sequencer running flag and shared counter
//   cap_last_i        clamped period minus one of the set being captured
//   cfg_tph_i         requested high time
//   cfg_delay_i       requested phase delay
//   pulse_o           registered pulse output
module multi_pulse_gen_channel
  import multi_pulse_gen_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MIN_TPH = DEF_MIN_TPH,
  parameter int MAX_TPH = DEF_MAX_TPH,
  parameter int DEF_TPH = DEF_HIGH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             apply_i,
  input  logic             busy_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] cap_last_i,
  input  logic [CNT_W-1:0] cfg_tph_i,
  input  logic [CNT_W-1:0] cfg_delay_i,
  output logic             pulse_o
);

  logic [CNT_W-1:0] tph_pend_q, tph_act_q, dly_pend_q, dly_act_q;
  logic [CNT_W-1:0] tph_clamp, tph_cap, dly_cap;
  logic [CNT_W:0]   win_end;
  logic             pulse_d, pulse_q;

  assign tph_clamp = CNT_W'(clamp_u(32'(cfg_tph_i), MIN_TPH, MAX_TPH));
  assign tph_cap   = (tph_clamp > cap_last_i) ? cap_last_i : tph_clamp;
  assign dly_cap   = (cfg_delay_i > cap_last_i) ? cap_last_i : cfg_delay_i;

  // One extra bit so delay+tph never overflows; windows running past the
  // period end are cut off naturally because cnt never exceeds P-1.
  assign win_end = {1'b0, dly_act_q} + {1'b0, tph_act_q};
  assign pulse_d = busy_i && (cnt_i >= dly_act_q) && ({1'b0, cnt_i} < win_end);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tph_pend_q <= CNT_W'(DEF_TPH);
      tph_act_q  <= CNT_W'(DEF_TPH);
      dly_pend_q <= '0;
      dly_act_q  <= '0;
      pulse_q    <= 1'b0;
    end else begin
      if (apply_i) begin
        tph_act_q <= tph_pend_q;
        dly_act_q <= dly_pend_q;
      end
      if (load_i) begin
        tph_pend_q <= tph_cap;
        dly_pend_q <= dly_cap;
      end
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel pulse generator: NUM_CH phase-aligned pulse outputs sharing
// one period counter, with double-buffered configuration applied only at a
// period boundary, continuous and N-period burst modes.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cfg_load            capture all cfg_* inputs into the pending set
//   cfg_period          requested period (clamped to MIN_T..MAX_T)
//   cfg_tph, cfg_delay  per-channel high time / phase delay, CNT_W each
//   cfg_burst           0 = continuous, N = run N periods
//   start, stop         begin generation / stop at end of current period
//   pulse_out           registered pulse outputs
//   period_start        strobe while running with counter at 0
//   busy                high while generating
//   done                1-cycle strobe after the final period
//   cfg_pending         pending configuration not yet applied
module multi_pulse_gen
  import multi_pulse_gen_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MIN_T   = DEF_MIN_T,
  parameter int MAX_T   = DEF_MAX_T,
  parameter int MIN_TPH = DEF_MIN_TPH,
  parameter int MAX_TPH = DEF_MAX_TPH,
  parameter int DEF_T   = DEF_PERIOD,
  parameter int DEF_TPH = DEF_HIGH,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_load,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_tph,
  input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
  input  logic [BURST_W-1:0]      cfg_burst,
  input  logic                    start,
  input  logic                    stop,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic                    period_start,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_pending
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d, burst_next, burst_eff;
  logic [BURST_W-1:0] burst_pend_q, burst_act_q;
  logic [CNT_W-1:0]   per_pend_q, per_act_q, per_clamp, per_last, cap_last;
  logic               pend_q, done_q, done_d;
  logic               running, wrap, apply;

  assign per_clamp = CNT_W'(clamp_u(32'(cfg_period), MIN_T, MAX_T));
  assign cap_last  = per_clamp - CNT_W'(1);
  assign per_last  = per_act_q - CNT_W'(1);

  assign running = (state_q != ST_IDLE);
  assign wrap    = running && (cnt_q == per_last);
  // Pending set moves to active when idle, or exactly at a period wrap so
  // a running period never sees a configuration change.
  assign apply   = pend_q && (!running || wrap);
  // Burst length that governs the period about to begin.
  assign burst_eff = apply ? burst_pend_q : burst_act_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_pend_q   <= CNT_W'(DEF_T);
      per_act_q    <= CNT_W'(DEF_T);
      burst_pend_q <= '0;
      burst_act_q  <= '0;
      pend_q       <= 1'b0;
    end else begin
      if (apply) begin
        per_act_q   <= per_pend_q;
        burst_act_q <= burst_pend_q;
      end
      // A load on the apply cycle keeps pending set for the next boundary.
      if (cfg_load) begin
        per_pend_q   <= per_clamp;
        burst_pend_q <= cfg_burst;
        pend_q       <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;
    // Burst periods are counted from the most recent configuration apply.
    burst_next  = apply ? BURST_W'(1) : burst_cnt_q + BURST_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          cnt_d       = '0;
          burst_cnt_d = BURST_W'(1);
          state_d     = (burst_eff == BURST_W'(1)) ? ST_LAST : ST_RUN;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          cnt_d       = '0;
          burst_cnt_d = burst_next;
          if (stop || ((burst_eff != BURST_W'(BURST_CONTINUOUS)) && (burst_next == burst_eff)))
            state_d = ST_LAST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // LAST doubles as the latched stop request.
          if (stop) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (wrap) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      burst_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      burst_cnt_q <= burst_cnt_d;
      done_q      <= done_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    multi_pulse_gen_channel #(
      .CNT_W   (CNT_W),
      .MIN_TPH (MIN_TPH),
      .MAX_TPH (MAX_TPH),
      .DEF_TPH (DEF_TPH)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .load_i      (cfg_load),
      .apply_i     (apply),
      .busy_i      (running),
      .cnt_i       (cnt_q),
      .cap_last_i  (cap_last),
      .cfg_tph_i   (cfg_tph[gi*CNT_W +: CNT_W]),
      .cfg_delay_i (cfg_delay[gi*CNT_W +: CNT_W]),
      .pulse_o     (pulse_out[gi])
    );
  end

  assign period_start = running && (cnt_q == '0);
  assign busy         = running;
  assign done         = done_q;
  assign cfg_pending  = pend_q;

endmodule

// File: tb/tb_multi_pulse_gen.sv
module tb_multi_pulse_gen;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    cfg_load, start, stop;
  logic [CNT_W-1:0]        cfg_period;
  logic [NUM_CH*CNT_W-1:0] cfg_tph, cfg_delay;
  logic [BURST_W-1:0]      cfg_burst;
  logic [NUM_CH-1:0]       pulse_out;
  logic                    period_start, busy, done, cfg_pending;

  always #5 clk = ~clk;

  multi_pulse_gen dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_period(cfg_period),
    .cfg_tph(cfg_tph), .cfg_delay(cfg_delay), .cfg_burst(cfg_burst),
    .start(start), .stop(stop), .pulse_out(pulse_out), .period_start(period_start),
    .busy(busy), .done(done), .cfg_pending(cfg_pending)
  );

  typedef struct { string name; int val; } exp_t;
  exp_t exp_q[$];
  int   obs_q[$];
  int   checks = 0;
  int   errors = 0;

  // Per-cycle trace, one entry per sample taken 1 time unit after posedge.
  logic [NUM_CH-1:0] tr_p[$];
  logic              tr_ps[$], tr_busy[$], tr_done[$], tr_pend[$];

  function automatic void expect_val(string n, int v);
    exp_t e;
    e.name = n;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic int obs4(logic [NUM_CH-1:0] v);
    return $isunknown(v) ? -1 : int'(v);
  endfunction

  function automatic logic trace_bit(int sel, int i);
    if (i < 0 || i >= tr_ps.size()) return 1'b0;
    case (sel)
      0: return tr_ps[i];
      1: return tr_busy[i];
      2: return tr_done[i];
      default: return tr_pend[i];
    endcase
  endfunction

  function automatic int count_set(int sel, int lo, int hi);
    int n;
    n = 0;
    for (int i = lo; i < hi && i < tr_ps.size(); i++)
      if (trace_bit(sel, i) === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_set(int sel, int from);
    for (int i = from; i < tr_ps.size(); i++)
      if (trace_bit(sel, i) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int nth_ps(int k);
    int seen;
    seen = 0;
    for (int i = 0; i < tr_ps.size(); i++)
      if (tr_ps[i] === 1'b1) begin
        if (seen == k) return i;
        seen++;
      end
    return -1;
  endfunction

  function automatic int count_hi(int ch, int lo, int hi);
    int n;
    logic [NUM_CH-1:0] v;
    n = 0;
    for (int i = lo; i < hi && i < tr_p.size(); i++) begin
      v = tr_p[i];
      if (v[ch] === 1'b1) n++;
    end
    return n;
  endfunction

  function automatic int first_hi(int ch, int from);
    logic [NUM_CH-1:0] v;
    for (int i = from; i < tr_p.size(); i++) begin
      v = tr_p[i];
      if (v[ch] === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic int bit_at(int ch, int i);
    logic [NUM_CH-1:0] v;
    if (i >= tr_p.size()) return -1;
    v = tr_p[i];
    return $isunknown(v[ch]) ? -1 : int'(v[ch]);
  endfunction

  task automatic clear_trace();
    tr_p.delete(); tr_ps.delete(); tr_busy.delete(); tr_done.delete(); tr_pend.delete();
  endtask

  // Advance n cycles, sampling outputs; strobes are released after one cycle.
  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tr_p.push_back(pulse_out);
      tr_ps.push_back(period_start);
      tr_busy.push_back(busy);
      tr_done.push_back(done);
      tr_pend.push_back(cfg_pending);
      cfg_load = 1'b0; start = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic set_defaults();
    cfg_period = 16'd2000;
    cfg_burst  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_tph[c*CNT_W +: CNT_W]   = 16'd250;
      cfg_delay[c*CNT_W +: CNT_W] = 16'd0;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; cfg_load = 1'b0; start = 1'b0; stop = 1'b0;
    set_defaults();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_trace();
  endtask

  task automatic test_reset();
    exp_t e; int o;
    reset_n = 1'b1; cfg_load = 1'b0; start = 1'b0; stop = 1'b0;
    set_defaults();
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    expect_val("rst_pulse_out", 0);    obs_q.push_back(obs4(pulse_out));
    expect_val("rst_busy", 0);         obs_q.push_back(obs4(NUM_CH'(busy)));
    expect_val("rst_done", 0);         obs_q.push_back(obs4(NUM_CH'(done)));
    expect_val("rst_period_start", 0); obs_q.push_back(obs4(NUM_CH'(period_start)));
    expect_val("rst_cfg_pending", 0);  obs_q.push_back(obs4(NUM_CH'(cfg_pending)));
    #1 reset_n = 1'b1;
    clear_trace();
    record(5);
    expect_val("rst_idle_busy_cycles", 0); obs_q.push_back(count_set(1, 0, 5));
    expect_val("rst_idle_pulse_hi", 0);    obs_q.push_back(count_hi(0, 0, 5));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got %0d, expected %0d", e.name, o, e.val); end
      else $display("check %s: got %0d", e.name, o);
    end
  endtask

  task automatic test_defaults();
    exp_t e; int o;
    apply_reset();
    expect_val("t1_first_ps_idx", 0);
    expect_val("t1_period1", 2000);
    expect_val("t1_period2", 2000);
    for (int c = 0; c < NUM_CH; c++) begin
      expect_val($sformatf("t1_first_hi_ch%0d", c), 1);
      expect_val($sformatf("t1_hi_len_ch%0d", c), 250);
    end
    start = 1'b1;
    record(4005);
    obs_q.push_back(nth_ps(0));
    obs_q.push_back(nth_ps(1) - nth_ps(0));
    obs_q.push_back(nth_ps(2) - nth_ps(1));
    for (int c = 0; c < NUM_CH; c++) begin
      obs_q.push_back(first_hi(c, 0));
      obs_q.push_back(count_hi(c, 1, 2001));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got %0d, expected %0d", e.name, o, e.val); end
      else $display("check %s: got %0d", e.name, o);
    end
  endtask

  task automatic test_clamp();
    exp_t e; int o;
    apply_reset();
    cfg_period = 16'd500;
    cfg_tph[0*CNT_W +: CNT_W] = 16'd5;
    cfg_tph[1*CNT_W +: CNT_W] = 16'd2000;
    cfg_load = 1'b1;
    expect_val("t2_pending_after_load", 1);
    expect_val("t2_pending_after_apply", 0);
    record(3);
    obs_q.push_back(int'(trace_bit(3, 0)));
    obs_q.push_back(int'(trace_bit(3, 1)));
    expect_val("t2_period_clamped", 1000);
    expect_val("t2_tph_ch0_min", 10);
    expect_val("t2_tph_ch1_max", 990);
    expect_val("t2_tph_ch2", 250);
    clear_trace();
    start = 1'b1;
    record(1005);
    obs_q.push_back(nth_ps(1) - nth_ps(0));
    obs_q.push_back(count_hi(0, 1, 1001));
    obs_q.push_back(count_hi(1, 1, 1001));
    obs_q.push_back(count_hi(2, 1, 1001));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got %0d, expected %0d", e.name, o, e.val); end
      else $display("check %s: got %0d", e.name, o);
    end
  endtask

  task automatic test_reload_busy();
    exp_t e; int o;
    apply_reset();
    start = 1'b1;
    record(701);
    // Counter reads 700 now; the load is sampled on this cycle.
    cfg_period = 16'd3000;
    cfg_load = 1'b1;
    expect_val("t3_pending_set", 1);
    expect_val("t3_pending_until_wrap", 1);
    expect_val("t3_pending_cleared_at_wrap", 0);
    expect_val("t3_period_current", 2000);
    expect_val("t3_period_next", 3000);
    expect_val("t3_hi_len_period1", 250);
    expect_val("t3_hi_len_period2", 250);
    expect_val("t3_first_hi_period2", 2001);
    record(4310);
    obs_q.push_back(int'(trace_bit(3, 701)));
    obs_q.push_back(int'(trace_bit(3, 1999)));
    obs_q.push_back(int'(trace_bit(3, 2000)));
    obs_q.push_back(nth_ps(1) - nth_ps(0));
    obs_q.push_back(nth_ps(2) - nth_ps(1));
    obs_q.push_back(count_hi(0, 1, 2001));
    obs_q.push_back(count_hi(0, 2001, 5001));
    obs_q.push_back(first_hi(0, 2000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got %0d, expected %0d", e.name, o, e.val); end
      else $display("check %s: got %0d", e.name, o);
    end
  endtask

  task automatic test_delay_trunc();
    exp_t e; int o;
    apply_reset();
    cfg_delay[2*CNT_W +: CNT_W] = 16'd1900;
    cfg_load = 1'b1;
    record(2);
    clear_trace();
    expect_val("t4_ch2_low_at_cnt0", 0);
    expect_val("t4_ch2_first_hi", 1901);
    expect_val("t4_ch2_hi_len", 100);
    expect_val("t4_ch2_hi_at_cnt1999", 1);
    expect_val("t4_ch2_low_at_next_cnt0", 0);
    expect_val("t4_ch0_hi_len", 250);
    start = 1'b1;
    record(2010);
    obs_q.push_back(bit_at(2, 1));
    obs_q.push_back(first_hi(2, 0));
    obs_q.push_back(count_hi(2, 1, 2001));
    obs_q.push_back(bit_at(2, 2000));
    obs_q.push_back(bit_at(2, 2001));
    obs_q.push_back(count_hi(0, 1, 2001));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got %0d, expected %0d", e.name, o, e.val); end
      else $display("check %s: got %0d", e.name, o);
    end
  endtask

  task automatic test_burst();
    exp_t e; int o, hi_after;
    apply_reset();
    cfg_burst = 8'd3;
    cfg_load = 1'b1;
    record(2);
    clear_trace();
    expect_val("t5_num_periods", 3);
    expect_val("t5_done_count", 1);
    expect_val("t5_done_idx", 6000);
    expect_val("t5_busy_last_cycle", 1);
    expect_val("t5_busy_after", 0);
    expect_val("t5_hi_total_ch0", 750);
    expect_val("t5_hi_after_done", 0);
    start = 1'b1;
    record(6100);
    hi_after = 0;
    for (int c = 0; c < NUM_CH; c++) hi_after += count_hi(c, 6000, 6100);
    obs_q.push_back(count_set(0, 0, 6100));
    obs_q.push_back(count_set(2, 0, 6100));
    obs_q.push_back(first_set(2, 0));
    obs_q.push_back(int'(trace_bit(1, 5999)));
    obs_q.push_back(count_set(1, 6000, 6100));
    obs_q.push_back(count_hi(0, 0, 6000));
    obs_q.push_back(hi_after);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got %0d, expected %0d", e.name, o, e.val); end
      else $display("check %s: got %0d", e.name, o);
    end
  endtask

  task automatic test_stop_and_reset();
    exp_t e; int o;
    apply_reset();
    start = 1'b1;
    record(101);
    // Counter reads 100 (inside the high window); stop is sampled now.
    stop = 1'b1;
    expect_val("t6_done_idx", 2000);
    expect_val("t6_done_count", 1);
    expect_val("t6_periods", 1);
    expect_val("t6_hi_len_ch0", 250);
    expect_val("t6_busy_before_wrap", 1);
    expect_val("t6_busy_after_stop", 0);
    record(2100);
    obs_q.push_back(first_set(2, 0));
    obs_q.push_back(count_set(2, 0, 2201));
    obs_q.push_back(count_set(0, 0, 2201));
    obs_q.push_back(count_hi(0, 1, 2201));
    obs_q.push_back(int'(trace_bit(1, 1999)));
    obs_q.push_back(count_set(1, 2000, 2201));

    clear_trace();
    start = 1'b1; stop = 1'b1;
    expect_val("t6_startstop_busy", 0);
    expect_val("t6_startstop_ps", 0);
    record(5);
    obs_q.push_back(count_set(1, 0, 5));
    obs_q.push_back(count_set(0, 0, 5));

    clear_trace();
    start = 1'b1;
    expect_val("t6_pulse_before_reset", 15);
    expect_val("t6_pulse_during_reset", 0);
    expect_val("t6_busy_during_reset", 0);
    expect_val("t6_no_resume_busy", 0);
    expect_val("t6_no_resume_pulse", 0);
    record(50);
    obs_q.push_back(obs4(tr_p[49]));
    reset_n = 1'b0;
    #1;
    obs_q.push_back(obs4(pulse_out));
    obs_q.push_back(obs4(NUM_CH'(busy)));
    @(posedge clk); #1 reset_n = 1'b1;
    clear_trace();
    record(10);
    obs_q.push_back(count_set(1, 0, 10));
    obs_q.push_back(count_hi(0, 0, 10));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s: got %0d, expected %0d", e.name, o, e.val); end
      else $display("check %s: got %0d", e.name, o);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_clamp();
    test_reload_busy();
    test_delay_trunc();
    test_burst();
    test_stop_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got cycle limit reached, expected test sequence to complete");
    $fatal(1, "watchdog expired");
  end

endmodule
